// File: rtl/xor_checker_if.sv
// +----------------------------------------------------------------------------+
// | Module      : xor_checker_if                                               |
// | Description : Vector stimulus and result/status bundle for xor_checker.    |
// |               Macro XOR_CHECKER_CAPTURE_EN adds first-failure capture.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface xor_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             START;
  logic             IN_VALID;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] F;
  logic             F_VALID;
  logic             PARITY;
  logic             MISMATCH;
  logic [CNT_W-1:0] PASS_CNT;
  logic [CNT_W-1:0] FAIL_CNT;
  logic             BUSY;
  logic             DONE;
  logic             ALL_PASS;
`ifdef XOR_CHECKER_CAPTURE_EN
  logic [CNT_W-1:0] FAIL_IDX;
  logic [WIDTH-1:0] FAIL_F;
  logic             FAIL_SEEN;
`endif

  modport master (
    output START, IN_VALID, A, B,
`ifdef XOR_CHECKER_CAPTURE_EN
    input  FAIL_IDX, FAIL_F, FAIL_SEEN,
`endif
    input  F, F_VALID, PARITY, MISMATCH, PASS_CNT, FAIL_CNT, BUSY, DONE, ALL_PASS
  );

  modport slave (
    input  START, IN_VALID, A, B,
`ifdef XOR_CHECKER_CAPTURE_EN
    output FAIL_IDX, FAIL_F, FAIL_SEEN,
`endif
    output F, F_VALID, PARITY, MISMATCH, PASS_CNT, FAIL_CNT, BUSY, DONE, ALL_PASS
  );
endinterface

`default_nettype wire

// File: rtl/xor_checker.sv
// +----------------------------------------------------------------------------+
// | Module      : xor_checker                                                  |
// | Description : Compares NVEC word pairs per run, reporting A^B and counts.  |
// |               Macro XOR_CHECKER_CAPTURE_EN adds first-failure capture.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module xor_checker #(
  parameter int WIDTH = 8,
  parameter int NVEC  = 16,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  xor_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NVEC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [WIDTH-1:0] r_f;
  logic             r_f_valid;
  logic             r_parity;
  logic             r_mismatch;
  logic             w_start_run;
  logic             w_accept;
  logic [WIDTH-1:0] w_xor;

  // START is only honoured outside RUN; a run in progress is never disturbed.
  assign w_start_run = (r_state != S_RUN) && bus.START;
  assign w_accept    = (r_state == S_RUN) && bus.IN_VALID;
  assign w_xor       = bus.A ^ bus.B;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.START) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && (r_idx == c_last_idx)) w_state_nxt = S_DONE;
      S_DONE:  if (bus.START) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_f        <= '0;
      r_f_valid  <= 1'b0;
      r_parity   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_run) begin
        r_idx      <= '0;
        r_pass_cnt <= '0;
        r_fail_cnt <= '0;
        r_f_valid  <= 1'b0;
      end else if (w_accept) begin
        r_f        <= w_xor;
        r_f_valid  <= 1'b1;
        r_parity   <= ^w_xor;
        r_mismatch <= |w_xor;
        r_idx      <= r_idx + 1'b1;
        // Counters stick at all-ones rather than wrapping.
        if (|w_xor) begin
          if (!(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + 1'b1;
        end else begin
          if (!(&r_pass_cnt)) r_pass_cnt <= r_pass_cnt + 1'b1;
        end
      end else begin
        r_f_valid <= 1'b0;
      end
    end
  end

`ifdef XOR_CHECKER_CAPTURE_EN
  logic [CNT_W-1:0] r_fail_idx;
  logic [WIDTH-1:0] r_fail_f;
  logic             r_fail_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_idx  <= '0;
      r_fail_f    <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_start_run) begin
      r_fail_idx  <= '0;
      r_fail_f    <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_accept && (|w_xor) && !r_fail_seen) begin
      r_fail_idx  <= r_idx;
      r_fail_f    <= w_xor;
      r_fail_seen <= 1'b1;
    end
  end

  assign bus.FAIL_IDX  = r_fail_idx;
  assign bus.FAIL_F    = r_fail_f;
  assign bus.FAIL_SEEN = r_fail_seen;
`endif

  assign bus.F        = r_f;
  assign bus.F_VALID  = r_f_valid;
  assign bus.PARITY   = r_parity;
  assign bus.MISMATCH = r_mismatch;
  assign bus.PASS_CNT = r_pass_cnt;
  assign bus.FAIL_CNT = r_fail_cnt;
  assign bus.BUSY     = (r_state == S_RUN);
  assign bus.DONE     = (r_state == S_DONE);
  assign bus.ALL_PASS = (r_state == S_DONE) && (r_fail_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_xor_checker.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_xor_checker                                               |
// | Description : Scoreboard bench for xor_checker (NVEC=4 and CNT_W=2 DUTs).  |
// |               Capture checks compiled when XOR_CHECKER_CAPTURE_EN is set.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xor_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_checker_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  xor_checker_if #(.WIDTH(8), .CNT_W(2))  bus1 ();

  xor_checker #(.WIDTH(8), .NVEC(4), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  xor_checker #(.WIDTH(8), .NVEC(3), .CNT_W(2))  u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [7:0] f;
    bit         parity;
    bit         mismatch;
    int         pass;
    int         fail;
    bit         done;
    bit         all_pass;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one slot per DUT.
  int m_nvec[2] = '{4, 3};
  int m_max[2]  = '{65535, 3};
  bit m_run[2];
  int m_idx[2];
  int m_pass[2];
  int m_fail[2];
  bit m_fseen[2];
  int m_fidx[2];
  logic [7:0] m_ff[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input bit st, input bit iv, input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin
      bus0.START = st; bus0.IN_VALID = iv; bus0.A = a; bus0.B = b;
    end else begin
      bus1.START = st; bus1.IN_VALID = iv; bus1.A = a; bus1.B = b;
    end
  endtask

  task automatic start_run(input int sel);
    drive(sel, 1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    m_run[sel]   = 1'b1;
    m_idx[sel]   = 0;
    m_pass[sel]  = 0;
    m_fail[sel]  = 0;
    m_fseen[sel] = 1'b0;
    m_fidx[sel]  = 0;
    m_ff[sel]    = 8'h00;
  endtask

  task automatic send_vec(input int sel, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] f;
    drive(sel, 1'b0, 1'b1, a, b);
    if (m_run[sel]) begin
      f = a ^ b;
      if (f == 8'h00) begin
        m_pass[sel] = (m_pass[sel] < m_max[sel]) ? m_pass[sel] + 1 : m_max[sel];
      end else begin
        m_fail[sel] = (m_fail[sel] < m_max[sel]) ? m_fail[sel] + 1 : m_max[sel];
        if (!m_fseen[sel]) begin
          m_fseen[sel] = 1'b1;
          m_fidx[sel]  = m_idx[sel];
          m_ff[sel]    = f;
        end
      end
      m_idx[sel]++;
      e.f        = f;
      e.parity   = ($countones(f) % 2) == 1;
      e.mismatch = (f != 8'h00);
      e.pass     = m_pass[sel];
      e.fail     = m_fail[sel];
      e.done     = (m_idx[sel] == m_nvec[sel]);
      e.all_pass = e.done && (m_fail[sel] == 0);
      if (e.done) m_run[sel] = 1'b0;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    tick();
    drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rand_vec(input int sel);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
    send_vec(sel, a, b);
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_f"},        64'(bus0.F),        64'h0);
    check({tag, "_f_valid"},  64'(bus0.F_VALID),  64'h0);
    check({tag, "_parity"},   64'(bus0.PARITY),   64'h0);
    check({tag, "_mismatch"}, 64'(bus0.MISMATCH), 64'h0);
    check({tag, "_pass_cnt"}, 64'(bus0.PASS_CNT), 64'h0);
    check({tag, "_fail_cnt"}, 64'(bus0.FAIL_CNT), 64'h0);
    check({tag, "_busy"},     64'(bus0.BUSY),     64'h0);
    check({tag, "_done"},     64'(bus0.DONE),     64'h0);
    check({tag, "_all_pass"}, 64'(bus0.ALL_PASS), 64'h0);
`ifdef XOR_CHECKER_CAPTURE_EN
    check({tag, "_fail_seen"}, 64'(bus0.FAIL_SEEN), 64'h0);
`endif
  endtask

  // Scoreboard monitors: every F_VALID cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.F_VALID === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL dut0_unexpected_f_valid: got F=%0h with empty scoreboard", bus0.F);
      end else begin
        e = q0.pop_front();
        check("dut0_f",        64'(bus0.F),        64'(e.f));
        check("dut0_parity",   64'(bus0.PARITY),   64'(e.parity));
        check("dut0_mismatch", 64'(bus0.MISMATCH), 64'(e.mismatch));
        check("dut0_pass_cnt", 64'(bus0.PASS_CNT), 64'(e.pass));
        check("dut0_fail_cnt", 64'(bus0.FAIL_CNT), 64'(e.fail));
        check("dut0_done",     64'(bus0.DONE),     64'(e.done));
        check("dut0_all_pass", 64'(bus0.ALL_PASS), 64'(e.all_pass));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus1.F_VALID === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_unexpected_f_valid: got F=%0h with empty scoreboard", bus1.F);
      end else begin
        e = q1.pop_front();
        check("dut1_f",        64'(bus1.F),        64'(e.f));
        check("dut1_pass_cnt", 64'(bus1.PASS_CNT), 64'(e.pass));
        check("dut1_fail_cnt", 64'(bus1.FAIL_CNT), 64'(e.fail));
        check("dut1_done",     64'(bus1.DONE),     64'(e.done));
        check("dut1_all_pass", 64'(bus1.ALL_PASS), 64'(e.all_pass));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    check_zero0("reset");
    rst = 1'b0;

    // IN_VALID while idle must be ignored.
    send_vec(0, 8'h12, 8'h34);
    check("idle_ignore_fvalid", 64'(bus0.F_VALID), 64'h0);

    // All-matching run.
    start_run(0);
    check("run_busy", 64'(bus0.BUSY), 64'h1);
    send_vec(0, 8'h00, 8'h00);
    send_vec(0, 8'hA5, 8'hA5);
    send_vec(0, 8'hFF, 8'hFF);
    send_vec(0, 8'h3C, 8'h3C);
    tick();
    check("hold_done",     64'(bus0.DONE),     64'h1);
    check("hold_all_pass", 64'(bus0.ALL_PASS), 64'h1);
    check("hold_pass_cnt", 64'(bus0.PASS_CNT), 64'd4);
    check("hold_f_valid",  64'(bus0.F_VALID),  64'h0);

    // Restart from DONE; mismatching vectors, stall with START ignored mid-run.
    start_run(0);
    check("restart_pass_clr", 64'(bus0.PASS_CNT), 64'h0);
    send_vec(0, 8'hA5, 8'h5A);
    send_vec(0, 8'h01, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(0, (i == 1), 1'b0, 8'h00, 8'h00);
      tick();
      check("stall_f_valid", 64'(bus0.F_VALID),  64'h0);
      check("stall_busy",    64'(bus0.BUSY),     64'h1);
      check("stall_fail",    64'(bus0.FAIL_CNT), 64'd2);
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    send_vec(0, 8'h00, 8'h00);
    send_vec(0, 8'h77, 8'h77);
    check("mixed_all_pass", 64'(bus0.ALL_PASS), 64'h0);
    check("mixed_done",     64'(bus0.DONE),     64'h1);

    // First-failure capture: mismatches at indices 2 and 3.
    start_run(0);
    send_vec(0, 8'h11, 8'h11);
    send_vec(0, 8'h22, 8'h22);
    send_vec(0, 8'hA5, 8'h5A);
    send_vec(0, 8'h01, 8'h00);
`ifdef XOR_CHECKER_CAPTURE_EN
    check("cap_fail_seen", 64'(bus0.FAIL_SEEN), 64'(m_fseen[0]));
    check("cap_fail_idx",  64'(bus0.FAIL_IDX),  64'(m_fidx[0]));
    check("cap_fail_f",    64'(bus0.FAIL_F),    64'(m_ff[0]));
`endif

    // Reset mid-run with START and IN_VALID high.
    start_run(0);
    send_vec(0, 8'h0F, 8'hF0);
    send_vec(0, 8'h44, 8'h44);
    drive(0, 1'b1, 1'b1, 8'h12, 8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    m_run[0] = 1'b0;
    m_run[1] = 1'b0;
    check_zero0("midrun_rst");

    // Randomized runs with random IN_VALID gaps.
    for (int r = 0; r < 6; r++) begin
      start_run(0);
      for (int v = 0; v < 4; v++) begin
        repeat ($urandom_range(0, 2)) tick();
        rand_vec(0);
      end
      check("rand_done",     64'(bus0.DONE),     64'h1);
      check("rand_pass_sum", 64'(bus0.PASS_CNT + bus0.FAIL_CNT), 64'd4);
    end

    // Narrow counters: all failing, restart from DONE clears counts.
    start_run(1);
    send_vec(1, 8'h01, 8'h02);
    send_vec(1, 8'h03, 8'h04);
    send_vec(1, 8'h05, 8'h06);
    check("sat_fail_cnt", 64'(bus1.FAIL_CNT), 64'd3);
    start_run(1);
    check("narrow_restart_clr", 64'(bus1.FAIL_CNT), 64'd0);
    send_vec(1, 8'h80, 8'h00);
    check("narrow_restart_cnt", 64'(bus1.FAIL_CNT), 64'd1);
    send_vec(1, 8'h09, 8'h0A);
    send_vec(1, 8'hFE, 8'h01);
    check("narrow_done", 64'(bus1.DONE), 64'h1);

    tick();
    tick();
    check("q0_drained", 64'(q0.size()), 64'h0);
    check("q1_drained", 64'(q1.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xor_checker.md
XOR_CHECKER -- requirements
Module: xor_checker

Interface
REQ-001 Parameter WIDTH, default 8: bit width of compared words A, B and result F.
REQ-002 Parameter NVEC, default 16: vectors accepted per run; legal range 1..2**CNT_W-1.
REQ-003 Parameter CNT_W, default 16: width of PASS_CNT, FAIL_CNT, FAIL_IDX.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 START  input  1  begins a run when sampled high in IDLE or DONE.
REQ-007 IN_VALID  input  1  A/B hold a vector this cycle.
REQ-008 A  input  WIDTH  word under test (DUT side).
REQ-009 B  input  WIDTH  expected word (reference side).
REQ-010 F  output  WIDTH  registered A XOR B of last accepted vector.
REQ-011 F_VALID  output  1  F, PARITY, MISMATCH valid this cycle.
REQ-012 PARITY  output  1  XOR-reduction of F.
REQ-013 MISMATCH  output  1  F nonzero for the vector currently on F.
REQ-014 PASS_CNT, FAIL_CNT  output  CNT_W each  matching / mismatching vector counts for current run.
REQ-015 BUSY  output  1  high in RUN.
REQ-016 DONE  output  1  high in DONE.
REQ-017 ALL_PASS  output  1  DONE high and FAIL_CNT zero.

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE->RUN on START; RUN->DONE on acceptance of vector NVEC; DONE->RUN on START; no other transitions.
REQ-019 Entering RUN clears PASS_CNT, FAIL_CNT, internal vector index and F_VALID on the same edge.
REQ-020 Vector accepted on an edge where state is RUN and IN_VALID is high; IN_VALID in IDLE or DONE is ignored.
REQ-021 Latency 1 cycle: edge accepting vector k loads F=A^B, PARITY, MISMATCH and sets F_VALID; F_VALID low in any cycle following an edge with no acceptance.
REQ-022 PASS_CNT or FAIL_CNT updates on the accepting edge, so counters include the vector shown while F_VALID is high.
REQ-023 Counters saturate at all-ones and never wrap.
REQ-024 START while in RUN is ignored; run continues undisturbed.
REQ-025 Last vector: transition to DONE on its accepting edge; DONE, ALL_PASS and final F_VALID rise in the same cycle.
REQ-026 DONE, ALL_PASS, counters, F hold in DONE until START or rst.
REQ-027 IN_VALID gaps in RUN stall the run indefinitely; no timeout.

Reset
REQ-028 rst high at an edge forces IDLE and zeroes F, F_VALID, PARITY, MISMATCH, PASS_CNT, FAIL_CNT, BUSY, DONE, ALL_PASS, vector index and capture registers.
REQ-029 rst has priority over START and IN_VALID in the same cycle, including mid-run.

Configuration
REQ-030 Macro XOR_CHECKER_CAPTURE_EN defined: adds outputs FAIL_IDX (CNT_W, index 0..NVEC-1 of first mismatching vector in run) and FAIL_F (WIDTH, its F value), plus FAIL_SEEN (1); captured once per run, held until next START or rst.
REQ-031 Macro undefined: FAIL_IDX, FAIL_F, FAIL_SEEN ports and logic absent; all other behaviour identical.

Verification
REQ-032 WIDTH=8, NVEC=4; START then vectors (00,00),(A5,A5),(FF,FF),(3C,3C) -> F=00 each, PASS_CNT=4, FAIL_CNT=0, DONE=1, ALL_PASS=1.
REQ-033 Vector (A5,5A) -> next cycle F=FF, MISMATCH=1, PARITY=0; (01,00) -> F=01, PARITY=1; FAIL_CNT increments each.
REQ-034 IN_VALID low 3 cycles mid-run -> F_VALID low those cycles, counters and BUSY held, run resumes.
REQ-035 rst asserted with START high after 2 vectors -> IDLE, all outputs 0; START after rst -> counters restart from 0.
REQ-036 CNT_W=2, NVEC=3, with 4 forced failing vectors over two START cycles (DONE->RUN restart) -> counters clear on restart; separate saturation check at 3 with CNT_W=2, NVEC=3 all failing -> FAIL_CNT=3.
REQ-037 With XOR_CHECKER_CAPTURE_EN: mismatches at indices 2 and 3 -> FAIL_SEEN=1, FAIL_IDX=2, FAIL_F equals vector-2 XOR.
